// File: rtl/cfg_reg_mux_gen.sv
// cfg_reg_mux_gen
// Configuration register bank written from the pad interface, with a registered
// debug mux for the IO pads. Sensor results are captured into shadow registers on
// the rising edge of each channel's done signal, and sticky done flags record which
// channels have finished. A selected shadow is read back for the logic analyser.
// Everything runs on clk_i. The pad write strobe is the only input that arrives
// asynchronously, and it is synchronised before use.
module cfg_reg_mux_gen #(
  parameter int REG_W    = 16,
  parameter int NUM_REGS = 4,
  parameter int MUX_W    = 6,
  parameter int NUM_MUX  = 8,
  parameter int SENS_N   = 4,
  parameter int TICK_W   = 12,
  parameter int DAC_W    = 6,
  localparam int ADR_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
  localparam int MADR_W  = (NUM_MUX > 1) ? $clog2(NUM_MUX) : 1,
  localparam int SSEL_W  = (SENS_N > 1) ? $clog2(SENS_N) : 1
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       reg_wr_i,
  input  logic [ADR_W-1:0]           reg_adr_i,
  input  logic [REG_W-1:0]           reg_dat_i,
  output logic [NUM_REGS*REG_W-1:0]  regs_o,
  input  logic [MADR_W-1:0]          mux_adr_i,
  input  logic [NUM_MUX*MUX_W-1:0]   mux_i,
  output logic [MUX_W-1:0]           mux_o,
  input  logic                       start_i,
  input  logic [SENS_N-1:0]          sens_done_i,
  input  logic [SENS_N*TICK_W-1:0]   sens_ticks_i,
  input  logic [SENS_N*DAC_W-1:0]    sens_dac_i,
  input  logic [SSEL_W-1:0]          sens_sel_i,
  output logic [TICK_W-1:0]          sens_ticks_o,
  output logic [DAC_W-1:0]           sens_dac_o,
  output logic [SENS_N-1:0]          done_flags_o
);

  // ---------------------------------------------------------------------------
  // Write path
  // ---------------------------------------------------------------------------
  logic             wr_meta;
  logic             wr_sync;
  logic             wr_sync_d;
  logic             wr_pulse;
  logic             wr_en_q;
  logic [ADR_W-1:0] wr_adr_q;
  logic [REG_W-1:0] wr_dat_q;
  logic             wr_adr_ok;
  logic [REG_W-1:0] regs_q [NUM_REGS];

  // Bring the pad strobe into clk_i through two flops, and keep one more delayed copy for edge detection
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_meta   <= 1'b0;
      wr_sync   <= 1'b0;
      wr_sync_d <= 1'b0;
    end else begin
      wr_meta   <= reg_wr_i;
      wr_sync   <= wr_meta;
      wr_sync_d <= wr_sync;
    end
  end

  // A strobe that is held high still yields only one pulse
  assign wr_pulse = wr_sync & ~wr_sync_d;

  // Capture address and data with the pulse; the stage lands the write three edges after the strobe is first sampled
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_en_q  <= 1'b0;
      wr_adr_q <= '0;
      wr_dat_q <= '0;
    end else begin
      wr_en_q <= wr_pulse;
      if (wr_pulse) begin
        wr_adr_q <= reg_adr_i;
        wr_dat_q <= reg_dat_i;
      end
    end
  end

  // Addresses past the last register (only possible when NUM_REGS is not a power of two) are dropped
  assign wr_adr_ok = (int'(wr_adr_q) < NUM_REGS);

  // Configuration register bank
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= '0;
      end
    end else if (wr_en_q && wr_adr_ok) begin
      regs_q[wr_adr_q] <= wr_dat_q;
    end
  end

  // Flatten the bank onto the output bus, register k at [k*REG_W +: REG_W]
  always_comb begin
    regs_o = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      regs_o[k*REG_W +: REG_W] = regs_q[k];
    end
  end

  // ---------------------------------------------------------------------------
  // Debug mux
  // ---------------------------------------------------------------------------
  logic [MUX_W-1:0] mux_arr [NUM_MUX];
  logic             mux_adr_ok;

  // Split the flattened mux inputs into individual words
  always_comb begin
    for (int k = 0; k < NUM_MUX; k++) begin
      mux_arr[k] = mux_i[k*MUX_W +: MUX_W];
    end
  end

  assign mux_adr_ok = (int'(mux_adr_i) < NUM_MUX);

  // Register the selected input, driving zero for a select past the last input
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mux_o <= '0;
    end else if (mux_adr_ok) begin
      mux_o <= mux_arr[mux_adr_i];
    end else begin
      mux_o <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Sensor capture and readback
  // ---------------------------------------------------------------------------
  logic [SENS_N-1:0] done_d;
  logic [SENS_N-1:0] done_rise;
  logic [SENS_N-1:0] flags_q;
  logic [TICK_W-1:0] ticks_in [SENS_N];
  logic [DAC_W-1:0]  dac_in   [SENS_N];
  logic [TICK_W-1:0] ticks_sh [SENS_N];
  logic [DAC_W-1:0]  dac_sh   [SENS_N];
  logic              sel_ok;

  // Split the flattened sensor results per channel
  always_comb begin
    for (int k = 0; k < SENS_N; k++) begin
      ticks_in[k] = sens_ticks_i[k*TICK_W +: TICK_W];
      dac_in[k]   = sens_dac_i[k*DAC_W +: DAC_W];
    end
  end

  // Keep the previous done levels so that only a low-to-high transition counts
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      done_d <= '0;
    end else begin
      done_d <= sens_done_i;
    end
  end

  assign done_rise = sens_done_i & ~done_d;

  // Each channel copies its results into its own shadow when its done signal rises
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int k = 0; k < SENS_N; k++) begin
        ticks_sh[k] <= '0;
        dac_sh[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < SENS_N; k++) begin
        if (done_rise[k]) begin
          ticks_sh[k] <= ticks_in[k];
          dac_sh[k]   <= dac_in[k];
        end
      end
    end
  end

  // Start clears the sticky flags, but a done edge in the same cycle still sets its flag
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      flags_q <= '0;
    end else if (start_i) begin
      flags_q <= done_rise;
    end else begin
      flags_q <= flags_q | done_rise;
    end
  end

  assign done_flags_o = flags_q;

  assign sel_ok = (int'(sens_sel_i) < SENS_N);

  // Register the selected shadow for readback, driving zero for a select past the last channel
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sens_ticks_o <= '0;
      sens_dac_o   <= '0;
    end else if (sel_ok) begin
      sens_ticks_o <= ticks_sh[sens_sel_i];
      sens_dac_o   <= dac_sh[sens_sel_i];
    end else begin
      sens_ticks_o <= '0;
      sens_dac_o   <= '0;
    end
  end

endmodule

// File: tb/tb_cfg_reg_mux_gen.sv
// tb_cfg_reg_mux_gen
// Directed bench for cfg_reg_mux_gen. A behavioural model predicts every output
// from the block's rules:
// - a write lands three edges after the strobe is first seen;
// - the mux output follows its select one cycle later;
// - shadows capture on done edges;
// - flags are sticky until start.
// The model is compared with the DUT on every falling edge. Literal expectations at
// key points pin the model itself. A second instance with NUM_REGS=3 and NUM_MUX=6
// covers the out-of-range address cases.
module tb_cfg_reg_mux_gen;

  logic        clk = 1'b0;
  logic        clk_run = 1'b0;
  logic        rst_n;
  logic        reg_wr;
  logic [1:0]  reg_adr;
  logic [15:0] reg_dat;
  logic [63:0] regs;
  logic [47:0] regs6;
  logic [2:0]  mux_adr;
  logic [47:0] mux_in;
  logic [5:0]  mux_out;
  logic [5:0]  mux_out6;
  logic        start;
  logic [3:0]  sens_done;
  logic [47:0] sens_ticks;
  logic [23:0] sens_dac;
  logic [1:0]  sens_sel;
  logic [11:0] ticks_out;
  logic [11:0] ticks_out6;
  logic [5:0]  dac_out;
  logic [5:0]  dac_out6;
  logic [3:0]  flags;
  logic [3:0]  flags6;

  int checks = 0;
  int errors = 0;
  logic check_en = 1'b0;

  cfg_reg_mux_gen dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .reg_wr_i     (reg_wr),
    .reg_adr_i    (reg_adr),
    .reg_dat_i    (reg_dat),
    .regs_o       (regs),
    .mux_adr_i    (mux_adr),
    .mux_i        (mux_in),
    .mux_o        (mux_out),
    .start_i      (start),
    .sens_done_i  (sens_done),
    .sens_ticks_i (sens_ticks),
    .sens_dac_i   (sens_dac),
    .sens_sel_i   (sens_sel),
    .sens_ticks_o (ticks_out),
    .sens_dac_o   (dac_out),
    .done_flags_o (flags)
  );

  cfg_reg_mux_gen #(.NUM_REGS(3), .NUM_MUX(6)) dut6 (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .reg_wr_i     (reg_wr),
    .reg_adr_i    (reg_adr),
    .reg_dat_i    (reg_dat),
    .regs_o       (regs6),
    .mux_adr_i    (mux_adr),
    .mux_i        (mux_in[35:0]),
    .mux_o        (mux_out6),
    .start_i      (start),
    .sens_done_i  (sens_done),
    .sens_ticks_i (sens_ticks),
    .sens_dac_i   (sens_dac),
    .sens_sel_i   (sens_sel),
    .sens_ticks_o (ticks_out6),
    .sens_dac_o   (dac_out6),
    .done_flags_o (flags6)
  );

  // Free-running clock once enabled, so the reset check can happen with no clock at all
  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  logic [15:0] m_regs  [4];
  logic [15:0] m_regs6 [3];
  int          due_q[$];
  int          cyc = 0;
  logic        wr_prev;
  logic [5:0]  m_mux;
  logic [5:0]  m_mux6;
  logic [11:0] m_sh_t [4];
  logic [5:0]  m_sh_d [4];
  logic [3:0]  m_flags;
  logic [3:0]  m_done_prev;
  logic [11:0] m_ticks;
  logic [5:0]  m_dac;

  // Predict the outputs from the block's rules, edge by edge
  always @(posedge clk or negedge rst_n) begin
    int          e;
    int          a;
    int          idx;
    int          sel;
    logic [3:0]  rise;
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        m_regs[k] <= '0;
        m_sh_t[k] <= '0;
        m_sh_d[k] <= '0;
      end
      for (int k = 0; k < 3; k++) m_regs6[k] <= '0;
      due_q.delete();
      wr_prev     <= 1'b0;
      m_mux       <= '0;
      m_mux6      <= '0;
      m_flags     <= '0;
      m_done_prev <= '0;
      m_ticks     <= '0;
      m_dac       <= '0;
    end else begin
      e = cyc + 1;
      cyc <= e;
      if (due_q.size() > 0 && due_q[0] == e) begin
        void'(due_q.pop_front());
        a = int'(reg_adr);
        if (a < 4) m_regs[a] <= reg_dat;
        if (a < 3) m_regs6[a] <= reg_dat;
      end
      if (reg_wr && !wr_prev) due_q.push_back(e + 3);
      wr_prev <= reg_wr;

      idx = int'(mux_adr);
      m_mux  <= (idx < 8) ? mux_in[idx*6 +: 6] : 6'h00;
      m_mux6 <= (idx < 6) ? mux_in[idx*6 +: 6] : 6'h00;

      sel = int'(sens_sel);
      m_ticks <= (sel < 4) ? m_sh_t[sel] : 12'h000;
      m_dac   <= (sel < 4) ? m_sh_d[sel] : 6'h00;

      rise = sens_done & ~m_done_prev;
      m_done_prev <= sens_done;
      for (int k = 0; k < 4; k++) begin
        if (rise[k]) begin
          m_sh_t[k] <= sens_ticks[k*12 +: 12];
          m_sh_d[k] <= sens_dac[k*6 +: 6];
        end
      end
      m_flags <= start ? rise : (m_flags | rise);
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance n rising edges, then step off the edge before driving inputs
  task automatic applyStimulus(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Compare every output against the model on each falling edge
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("regs",   regs,      {m_regs[3], m_regs[2], m_regs[1], m_regs[0]});
      checkOutput("regs6",  regs6,     {m_regs6[2], m_regs6[1], m_regs6[0]});
      checkOutput("mux",    mux_out,   m_mux);
      checkOutput("mux6",   mux_out6,  m_mux6);
      checkOutput("ticks",  ticks_out, m_ticks);
      checkOutput("dac",    dac_out,   m_dac);
      checkOutput("flags",  flags,     m_flags);
      checkOutput("flags6", flags6,    m_flags);
    end
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst_n      = 1'b0;
    reg_wr     = 1'b0;
    reg_adr    = '0;
    reg_dat    = '0;
    mux_adr    = '0;
    mux_in     = '0;
    start      = 1'b0;
    sens_done  = '0;
    sens_ticks = '0;
    sens_dac   = '0;
    sens_sel   = '0;

    // Reset with no clock running
    #20;
    $display("[TB] reset check without clock");
    checkOutput("rst_regs",  regs,      64'h0);
    checkOutput("rst_regs6", regs6,     64'h0);
    checkOutput("rst_mux",   mux_out,   64'h0);
    checkOutput("rst_ticks", ticks_out, 64'h0);
    checkOutput("rst_dac",   dac_out,   64'h0);
    checkOutput("rst_flags", flags,     64'h0);

    for (int k = 0; k < 8; k++) mux_in[k*6 +: 6] = 6'(k*7 + 3);
    mux_in[5*6 +: 6] = 6'h2A;
    clk_run  = 1'b1;
    check_en = 1'b1;
    applyStimulus(2);
    rst_n = 1'b1;
    applyStimulus(2);

    // Write 16'hA5C3 to register 2 with the strobe held for five cycles
    $display("[TB] write test");
    reg_adr = 2'd2;
    reg_dat = 16'hA5C3;
    reg_wr  = 1'b1;
    applyStimulus(3);
    @(negedge clk);
    checkOutput("wr_before", regs, 64'h0);
    applyStimulus(1);
    @(negedge clk);
    checkOutput("wr_land", regs, 64'h0000_A5C3_0000_0000);
    applyStimulus(1);
    reg_wr  = 1'b0;
    reg_dat = 16'h1111;
    applyStimulus(6);
    @(negedge clk);
    checkOutput("wr_once",  regs,  64'h0000_A5C3_0000_0000);
    checkOutput("wr_once6", regs6, 64'h0000_A5C3_0000_0000);

    // Address 3 exists in the four-register instance but not in the three-register one
    $display("[TB] out-of-range write test");
    applyStimulus(1);
    reg_adr = 2'd3;
    reg_dat = 16'hBEEF;
    reg_wr  = 1'b1;
    applyStimulus(2);
    reg_wr = 1'b0;
    applyStimulus(6);
    @(negedge clk);
    checkOutput("oor_regs",  regs,  64'hBEEF_A5C3_0000_0000);
    checkOutput("oor_regs6", regs6, 64'h0000_A5C3_0000_0000);

    // Debug mux
    $display("[TB] mux test");
    applyStimulus(1);
    mux_adr = 3'd5;
    applyStimulus(1);
    @(negedge clk);
    checkOutput("mux5",  mux_out,  64'h2A);
    checkOutput("mux5b", mux_out6, 64'h2A);
    applyStimulus(1);
    mux_adr = 3'd7;
    applyStimulus(1);
    @(negedge clk);
    checkOutput("mux7",  mux_out,  64'h34);
    checkOutput("mux7b", mux_out6, 64'h00);

    // Capture channel 1
    $display("[TB] capture test");
    applyStimulus(1);
    sens_ticks[12 +: 12] = 12'h3E8;
    sens_dac[6 +: 6]     = 6'h15;
    sens_done[1]         = 1'b1;
    applyStimulus(1);
    sens_done[1] = 1'b0;
    @(negedge clk);
    checkOutput("cap_flags", flags, 64'b0010);
    applyStimulus(1);
    sens_sel = 2'd1;
    applyStimulus(1);
    @(negedge clk);
    checkOutput("cap_ticks", ticks_out, 64'h3E8);
    checkOutput("cap_dac",   dac_out,   64'h15);
    applyStimulus(1);
    sens_ticks[12 +: 12] = 12'h777;
    sens_dac[6 +: 6]     = 6'h3F;
    applyStimulus(3);
    @(negedge clk);
    checkOutput("hold_ticks", ticks_out, 64'h3E8);
    checkOutput("hold_dac",   dac_out,   64'h15);

    // Start colliding with a channel 3 done edge
    $display("[TB] collision test");
    applyStimulus(1);
    sens_ticks[0 +: 12] = 12'h123;
    sens_dac[0 +: 6]    = 6'h01;
    sens_done[0]        = 1'b1;
    applyStimulus(1);
    sens_done[0] = 1'b0;
    @(negedge clk);
    checkOutput("col_pre", flags, 64'b0011);
    applyStimulus(1);
    sens_ticks[36 +: 12] = 12'hABC;
    sens_dac[18 +: 6]    = 6'h2F;
    start        = 1'b1;
    sens_done[3] = 1'b1;
    applyStimulus(1);
    start        = 1'b0;
    sens_done[3] = 1'b0;
    @(negedge clk);
    checkOutput("col_flags", flags, 64'b1000);
    applyStimulus(1);
    sens_sel = 2'd3;
    applyStimulus(1);
    @(negedge clk);
    checkOutput("col_ticks", ticks_out, 64'hABC);
    checkOutput("col_dac",   dac_out,   64'h2F);

    // A done level held through a start pulse does not set its flag again
    $display("[TB] held done test");
    applyStimulus(1);
    sens_done[2] = 1'b1;
    applyStimulus(2);
    @(negedge clk);
    checkOutput("held_set", flags, 64'b1100);
    applyStimulus(1);
    start = 1'b1;
    applyStimulus(1);
    start = 1'b0;
    applyStimulus(2);
    sens_done[2] = 1'b0;
    @(negedge clk);
    checkOutput("held_clr", flags, 64'b0000);

    // Reset one cycle after the strobe rises
    $display("[TB] reset mid-write test");
    applyStimulus(1);
    reg_adr = 2'd1;
    reg_dat = 16'h5A5A;
    reg_wr  = 1'b1;
    applyStimulus(1);
    rst_n  = 1'b0;
    reg_wr = 1'b0;
    #1;
    checkOutput("mid_regs_now", regs,  64'h0);
    checkOutput("mid_flags",    flags, 64'h0);
    applyStimulus(2);
    rst_n = 1'b1;
    applyStimulus(6);
    @(negedge clk);
    checkOutput("mid_regs",  regs,      64'h0);
    checkOutput("mid_regs6", regs6,     64'h0);
    checkOutput("mid_ticks", ticks_out, 64'h0);
    applyStimulus(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
